// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: write side, read side, flush and status.
// The master drives requests and data; the slave (the FIFO) returns data and flags.
interface sync_fifo_param_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) ();
    logic             clr;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             walmost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, winc, wdata, rinc,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, winc, wdata, rinc,
        output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered flags, fill count, sticky error flags,
// synchronous flush and a selectable first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AF_THRESH = (1 << ASIZE) - 2,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int             DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] AF_LVL  = AF_THRESH[ASIZE:0];
    localparam logic [ASIZE:0] AE_LVL  = AE_THRESH[ASIZE:0];
    localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             walmost_full_q, walmost_full_d;
    logic             ralmost_empty_q, ralmost_empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_en, rd_en;
    logic [ASIZE-1:0] waddr, raddr;

    assign waddr = wptr_q[ASIZE-1:0];
    assign raddr = rptr_q[ASIZE-1:0];

    // Accept decisions use the registered flags, so a full FIFO still takes a
    // read and an empty FIFO still takes a write on a simultaneous request.
    assign wr_en = bus.winc && !wfull_q && !bus.clr;
    assign rd_en = bus.rinc && !rempty_q && !bus.clr;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en) wptr_d = wptr_q + PTR_ONE;
            if (rd_en) rptr_d = rptr_q + PTR_ONE;
            if (wr_en && !rd_en)      count_d = count_q + PTR_ONE;
            else if (rd_en && !wr_en) count_d = count_q - PTR_ONE;
            if (bus.winc && wfull_q)  overflow_d  = 1'b1;
            if (bus.rinc && rempty_q) underflow_d = 1'b1;
        end
        wfull_d         = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
                          (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
        rempty_d        = (wptr_d == rptr_d);
        walmost_full_d  = (count_d >= AF_LVL);
        ralmost_empty_d = (count_d <= AE_LVL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            wfull_q         <= 1'b0;
            rempty_q        <= 1'b1;
            walmost_full_q  <= 1'b0;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            wfull_q         <= wfull_d;
            rempty_q        <= rempty_d;
            walmost_full_q  <= walmost_full_d;
            ralmost_empty_q <= ralmost_empty_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem[waddr] <= bus.wdata;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is driven straight from the array; forced to 0 while empty.
            assign bus.rdata = rempty_q ? '0 : mem[raddr];
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = rdata_q;
                if (rd_en) rdata_d = mem[raddr];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rdata_q <= '0;
                else        rdata_q <= rdata_d;
            end

            assign bus.rdata = rdata_q;
        end
    endgenerate

    assign bus.count         = count_q;
    assign bus.wfull         = wfull_q;
    assign bus.rempty        = rempty_q;
    assign bus.walmost_full  = walmost_full_q;
    assign bus.ralmost_empty = ralmost_empty_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read instance checked against a queue
// scoreboard and a vector table, plus an FWFT instance driven by hand.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    string phase = "init";

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DSIZE(8), .ASIZE(4)) f0 ();
    sync_fifo_param_if #(.DSIZE(8), .ASIZE(4)) f1 ();

    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .bus(f0));
    sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .bus(f1));

    logic [7:0] sb[$];
    logic [7:0] m_rdata = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    typedef struct {
        logic       w;
        logic       r;
        logic       c;
        logic [7:0] d;
        int         cnt;
        logic       ovf;
        logic       udf;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s]: got %0h expected %0h", name, phase, act, exp);
        end
    endtask

    // Drives one cycle on the standard instance and checks every output
    // against the queue model after the edge.
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        bit m_full, m_empty;
        f0.winc = w; f0.rinc = r; f0.clr = c; f0.wdata = d;
        m_full  = (sb.size() == 16);
        m_empty = (sb.size() == 0);
        if (c) begin
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && m_full)  m_ovf = 1'b1;
            if (r && m_empty) m_udf = 1'b1;
            if (r && !m_empty) m_rdata = sb.pop_front();
            if (w && !m_full) sb.push_back(d);
        end
        @(posedge clk); #1;
        f0.winc = 1'b0; f0.rinc = 1'b0; f0.clr = 1'b0;
        chk("count",         f0.count,         sb.size());
        chk("wfull",         f0.wfull,         sb.size() == 16);
        chk("rempty",        f0.rempty,        sb.size() == 0);
        chk("walmost_full",  f0.walmost_full,  sb.size() >= 14);
        chk("ralmost_empty", f0.ralmost_empty, sb.size() <= 2);
        chk("overflow",      f0.overflow,      m_ovf);
        chk("underflow",     f0.underflow,     m_udf);
        chk("rdata",         f0.rdata,         m_rdata);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_full_and_empty_f0", f0.wfull && f0.rempty, 1'b0);
            chk("inv_full_vs_count_f0",  f0.wfull, f0.count == 5'd16);
            chk("inv_empty_vs_count_f0", f0.rempty, f0.count == 5'd0);
            chk("inv_full_and_empty_f1", f1.wfull && f1.rempty, 1'b0);
            chk("inv_full_vs_count_f1",  f1.wfull, f1.count == 5'd16);
            chk("inv_empty_vs_count_f1", f1.rempty, f1.count == 5'd0);
            chk("inv_no_x_inputs", $isunknown({f0.winc, f0.rinc, f0.wdata, f1.winc, f1.rinc, f1.wdata}), 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d errors of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_n, rd_n, iter, op;
        bit can_w, can_r, do_w, do_r;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h31, 1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h32, 2, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0};

        f0.winc = 1'b0; f0.rinc = 1'b0; f0.clr = 1'b0; f0.wdata = 8'h00;
        f1.winc = 1'b0; f1.rinc = 1'b0; f1.clr = 1'b0; f1.wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        phase = "reset";
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b0, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        f0.winc = 1'b1; f0.wdata = 8'h33;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rempty",        f0.rempty,        1'b1);
        chk("rst_wfull",         f0.wfull,         1'b0);
        chk("rst_count",         f0.count,         0);
        chk("rst_ralmost_empty", f0.ralmost_empty, 1'b1);
        chk("rst_walmost_full",  f0.walmost_full,  1'b0);
        chk("rst_overflow",      f0.overflow,      1'b0);
        chk("rst_underflow",     f0.underflow,     1'b0);
        chk("rst_rdata",         f0.rdata,         8'h00);
        chk("rst_rempty_fwft",   f1.rempty,        1'b1);
        f0.winc = 1'b0; f0.wdata = 8'h00;
        sb.delete(); m_rdata = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);

        phase = "fill";
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, i[7:0]);
            if (i == 12) chk("fill_af_before", f0.walmost_full, 1'b0);
            if (i == 13) chk("fill_af_rise",   f0.walmost_full, 1'b1);
        end
        chk("fill_wfull", f0.wfull, 1'b1);
        chk("fill_count", f0.count, 16);

        phase = "overflow";
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        chk("ovf_flag",  f0.overflow, 1'b1);
        chk("ovf_count", f0.count,    16);

        phase = "drain";
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            chk("drain_rdata", f0.rdata, i);
        end
        chk("drain_rempty", f0.rempty, 1'b1);

        phase = "table";
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
            chk("tbl_count",     f0.count,     tbl[i].cnt);
            chk("tbl_overflow",  f0.overflow,  tbl[i].ovf);
            chk("tbl_underflow", f0.underflow, tbl[i].udf);
        end
        chk("udf_rdata_held", f0.rdata, 8'h0F);

        phase = "simultaneous";
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h40 + i[7:0]);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h50 + i[7:0]);
            chk("sim_count_steady", f0.count, 5);
        end
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, 8'h60 + i[7:0]);
        chk("sim_full", f0.wfull, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        chk("sim_full_count", f0.count,    15);
        chk("sim_full_ovf",   f0.overflow, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        phase = "wrap";
        wr_n = 0; rd_n = 0; iter = 0;
        while ((wr_n < 40 || rd_n < 40) && iter < 1000) begin
            iter++;
            op    = int'($urandom_range(0, 2));
            can_w = (wr_n < 40) && (sb.size() < 15);
            can_r = (rd_n < 40) && (sb.size() > 0) && ((sb.size() > 1) || (wr_n == 40));
            do_w  = can_w && (op != 1);
            do_r  = can_r && (op != 0);
            if (!do_w && !do_r) begin
                do_w = can_w;
                do_r = can_r && !can_w;
            end
            step(do_w, do_r, 1'b0, 8'($urandom));
            if (do_w) wr_n++;
            if (do_r) rd_n++;
        end
        chk("wrap_writes", wr_n, 40);
        chk("wrap_reads",  rd_n, 40);

        phase = "fwft";
        f1.winc = 1'b1; f1.wdata = 8'h5A;
        @(posedge clk); #1 f1.winc = 1'b0;
        chk("fwft_rempty_fall", f1.rempty, 1'b0);
        chk("fwft_rdata_first", f1.rdata,  8'h5A);
        @(posedge clk); #1;
        chk("fwft_rdata_hold",  f1.rdata,  8'h5A);
        f1.rinc = 1'b1;
        @(posedge clk); #1 f1.rinc = 1'b0;
        chk("fwft_rempty_rise", f1.rempty, 1'b1);
        chk("fwft_count_zero",  f1.count,  0);
        f1.winc = 1'b1; f1.wdata = 8'h11;
        @(posedge clk); #1 f1.wdata = 8'h22;
        @(posedge clk); #1 f1.winc = 1'b0;
        chk("fwft_head_1", f1.rdata, 8'h11);
        f1.rinc = 1'b1;
        @(posedge clk); #1;
        chk("fwft_head_2", f1.rdata, 8'h22);
        @(posedge clk); #1 f1.rinc = 1'b0;
        chk("fwft_drained", f1.rempty, 1'b1);
        f1.winc = 1'b1; f1.rinc = 1'b1; f1.wdata = 8'h77;
        @(posedge clk); #1 f1.winc = 1'b0; f1.rinc = 1'b0;
        chk("fwft_empty_sim_count", f1.count,     1);
        chk("fwft_empty_sim_udf",   f1.underflow, 1'b1);
        chk("fwft_empty_sim_rdata", f1.rdata,     8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO. Same winc/wdata/wfull and rinc/rdata/rempty handshake.
- Adds almost-full and almost-empty thresholds, a fill count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Used as a rate-matching buffer inside a single clock domain, and as the reference model target for the FIFO verification environment.

Parameters:
- DSIZE, 8, data word width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries.
- AF_THRESH, DEPTH-2, walmost_full asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 2, ralmost_empty asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; empties the FIFO and clears error flags.
- winc  input  1  write request.
- wdata  input  DSIZE  write data.
- wfull  output  1  FIFO holds DEPTH entries.
- walmost_full  output  1  count >= AF_THRESH.
- rinc  input  1  read request.
- rdata  output  DSIZE  read data.
- rempty  output  1  FIFO holds 0 entries.
- ralmost_empty  output  1  count <= AE_THRESH.
- count  output  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a write was attempted while full.
- underflow  output  1  sticky; a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous): pointers and count go to 0.
  - rempty=1, wfull=0, ralmost_empty=1, walmost_full=0.
  - overflow=0, underflow=0, rdata=0.
  - Memory contents are not reset.
- Reset deasserts synchronously to clk; the first handshake is honoured on the first rising edge with rst_n high.
- Pointers are ASIZE+1 bits. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal. Addresses wrap modulo DEPTH.
- Write accepted on an edge iff winc && !wfull: mem[wptr] <= wdata, wptr increments.
- Read accepted on an edge iff rinc && !rempty: rptr increments.
- All flags and count are registered and reflect the state after the edge; latency from an accepted event to a flag change is 1 cycle.
- count update: +1 on write-only, -1 on read-only, unchanged when both are accepted or neither.
- Simultaneous winc && rinc:
  - When full: read accepted, write rejected, overflow set.
  - When empty: write accepted, read rejected, underflow set. FWFT does not bypass.
  - Otherwise: both accepted.
- Standard mode (FWFT=0): on an accepted read, rdata <= mem[rptr] at that edge (valid 1 cycle after the rinc sample). rdata holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1): rdata presents mem[rptr] whenever rempty=0; rinc consumes it.
  - The first written word appears on rdata in the cycle after its write edge, when rempty falls.
  - rdata is don't-care while rempty=1; checkers must not sample it then.
- Sticky flags: overflow <= 1 on winc && wfull; underflow <= 1 on rinc && rempty. Both are cleared only by clr or reset.
- clr has priority over winc and rinc on the same edge. Pointers and count go to 0, flags return to their reset values, and errors clear. rdata holds in standard mode.
- Reset mid-operation: all in-flight contents are discarded immediately; no partial write completes.
- Assertions in the bench:
  - Never (wfull && rempty).
  - count == DEPTH iff wfull; count == 0 iff rempty.
  - No X on winc/rinc/wdata while rst_n is high.

Test Plan:
- Reset check (DSIZE=8, ASIZE=4): assert rst_n low mid-clock -> immediately rempty=1, wfull=0, count=0, ralmost_empty=1, overflow=0, underflow=0, rdata=0.
- Fill then drain, standard mode: write 0x00..0x0F in 16 cycles.
  - Expect walmost_full rising after the 14th write, and wfull=1 with count=16 after the 16th.
  - Read 16 -> rdata 0x00..0x0F, each one cycle after its rinc; rempty=1 after the last read.
- Error flags: when full, winc with wdata=0xAA -> overflow=1, count stays 16, 0xAA is never read. When empty, rinc -> underflow=1, rdata unchanged. Then clr -> both flags 0, count=0.
- Simultaneous access: at count=5, winc+rinc for 10 cycles -> count stays 5 and data order is preserved. When full, winc+rinc -> count=15, overflow=1. When empty, winc+rinc -> count=1, underflow=1.
- FWFT=1: write 0x5A to an empty FIFO -> next cycle rempty=0 and rdata=0x5A without rinc; rinc -> rempty=1 the following cycle.
- Wrap-around: perform 40 writes and 40 reads interleaved at random with occupancy kept at 1..15 -> all data match the scoreboard in order, with pointers wrapping twice and no flag glitches.
